wb_trace_buffer: RTL and testbench
==================================

// Module: wb_trace_buffer
// PURPOSE
//  Parametrised retirement-trace capture unit. Sits beside the CPU top and snoops the
//  writeback debug bus (have_inst/pc/ena/reg/value) at one record per cycle.
//  Records are sequence-numbered, optionally filtered, trigger-gated, and buffered
//  in a DEPTH-entry circular store drained through a valid/ready port.
//  Modes: drop-new or overwrite-oldest when full.
// PARAMETERS
//  XLEN   32  width of pc/value fields
//  REGW   5   width of register-index field
//  DEPTH  16  buffer entries; power of two, >=2
//  SEQW   16  width of retire sequence number; wraps modulo 2^SEQW
// PORTS
//  cpu_clk      in  1        clock
//  cpu_rst      in  1        reset, asynchronous, active-low
//  wb_have_inst in  1        one instruction retires this cycle
//  wb_pc        in  XLEN     retired pc
//  wb_ena       in  1        retired inst writes a GPR
//  wb_reg       in  REGW     destination register
//  wb_value     in  XLEN     write value
//  clr          in  1        sync clear: buffer, seq, counters, FSM->IDLE
//  cfg_en       in  1        capture enable
//  cfg_filter   in  1        1: keep only records with wb_ena && wb_reg!=0
//  cfg_wrap     in  1        1: overwrite oldest when full; 0: drop new
//  cfg_trig_en  in  1        1: wait for wb_pc==cfg_trig_pc before capturing
//  cfg_trig_pc  in  XLEN     trigger pc
//  cfg_post     in  16       records to capture after trigger; 0 = unlimited
//  out_valid    out 1        head record available
//  out_ready    in  1        consumer accepts head
//  out_pc/out_value out XLEN; out_reg out REGW; out_ena out 1; out_seq out SEQW
//  level        out clog2(DEPTH)+1  entries held
//  drop_cnt     out 16       lost records (dropped or overwritten), saturates 16'hFFFF
//  overflow     out 1        sticky: any loss since reset/clr
//  state        out 2        FSM: 0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
// BEHAVIOUR
//  Reset (cpu_rst=0, async) and clr: pointers, level, seq, drop_cnt, post counter = 0;
//   overflow=0; state=IDLE; out_valid=0; out_* = 0. clr has priority over all else.
//  seq: increments on every wb_have_inst regardless of state/filter; record carries
//   pre-increment value (first retirement after reset has seq 0).
//  FSM: IDLE->ARMED when cfg_en=1. ARMED->CAPTURE when cfg_trig_en=0, or on
//   wb_have_inst && wb_pc==cfg_trig_pc (triggering record itself is captured).
//   CAPTURE->DONE when post count reaches cfg_post (cfg_post!=0). Any state->IDLE when
//   cfg_en=0; buffer contents retained and drainable in every state.
//  Candidate = wb_have_inst && state==CAPTURE (incl. trigger cycle) && (!cfg_filter ||
//   (wb_ena && wb_reg!=0)). Post counter counts candidates only.
//  Push written at cpu_clk edge; out_valid rises the next cycle if buffer was empty.
//  out_valid = (level!=0); out_* show-ahead from head entry; pop on out_valid&&out_ready.
//  Not full: push -> level+1 (or unchanged with simultaneous pop).
//  Full, pop same cycle: push accepted, level stays DEPTH, no loss (both modes).
//  Full, no pop, cfg_wrap=0: new record dropped; drop_cnt+1; overflow=1.
//  Full, no pop, cfg_wrap=1: oldest overwritten, head advances; drop_cnt+1; overflow=1.
//   Only case where out_* may change while out_valid && !out_ready.
//  Pop on empty ignored. Pointers wrap modulo DEPTH; level never exceeds DEPTH.
// TESTING
//  T1 reset, cfg_en=1, trig off; retire pc 0x0,0x4,0x8 (ena=1,reg=1..3) -> out_valid
//   next cycle, drained seq 0,1,2 in order, pc 0x0/0x4/0x8, level back to 0.
//  T2 cfg_filter=1; retire 4 insts, reg=0,5,x(ena=0),7 -> only reg 5 (seq1), reg 7 (seq3).
//  T3 DEPTH=16, cfg_wrap=0, out_ready=0, 20 retirements -> level=16, seq 0..15 held,
//   drop_cnt=4, overflow=1; then wrap=1 run -> seq 4..19 held, drop_cnt=4.
//  T4 cfg_trig_en=1, trig_pc=0x100, cfg_post=3; pcs 0xF8..0x114 -> captures 0x100,0x104,
//   0x108 only; state=DONE; further retirements ignored.
//  T5 full with out_ready=1 and push every cycle -> level stays 16, drop_cnt=0.
//  T6 cpu_rst low mid-capture (level=5) -> level=0, out_valid=0, state=IDLE, seq=0.

Source files
------------

// File: rtl/wb_trace_buffer_if.sv
// Writeback snoop bus and trace drain port of the retirement trace buffer.
// The master side is the CPU/consumer and the slave side is the trace buffer.
interface wb_trace_buffer_if #(
  parameter int XLEN = 32,
  parameter int REGW = 5,
  parameter int SEQW = 16
);
  logic            wb_have_inst;
  logic [XLEN-1:0] wb_pc;
  logic            wb_ena;
  logic [REGW-1:0] wb_reg;
  logic [XLEN-1:0] wb_value;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_value;
  logic [REGW-1:0] out_reg;
  logic            out_ena;
  logic [SEQW-1:0] out_seq;

  modport master (
    output wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, out_ready,
    input  out_valid, out_pc, out_value, out_reg, out_ena, out_seq
  );

  modport slave (
    input  wb_have_inst, wb_pc, wb_ena, wb_reg, wb_value, out_ready,
    output out_valid, out_pc, out_value, out_reg, out_ena, out_seq
  );
endinterface

// File: rtl/wb_trace_buffer.sv
// Retirement trace capture: sequence-numbered, filtered, trigger-gated records
// held in a circular store and drained through a show-ahead valid/ready port.
module wb_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int REGW  = 5,
  parameter int DEPTH = 16,
  parameter int SEQW  = 16
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rst,
  wb_trace_buffer_if.slave         bus,
  input  logic                     clr,
  input  logic                     cfg_en,
  input  logic                     cfg_filter,
  input  logic                     cfg_wrap,
  input  logic                     cfg_trig_en,
  input  logic [XLEN-1:0]          cfg_trig_pc,
  input  logic [15:0]              cfg_post,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic [1:0]               state
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CAPT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] value;
    logic [REGW-1:0] rd;
    logic            ena;
    logic [SEQW-1:0] seq;
  } rec_t;

  state_e          r_state;
  rec_t            r_mem [DEPTH];
  logic [AW-1:0]   r_head, r_tail;
  logic [AW:0]     r_level;
  logic [SEQW-1:0] r_seq;
  logic [15:0]     r_post, r_drop;
  logic            r_ovf;

  logic        w_hit, w_cand, w_full, w_pop, w_lose, w_wr, w_inc, w_adv_head, w_done;
  logic [15:0] w_post_nxt;
  rec_t        w_rec, w_head_rec;

  // The trigger record itself is captured in the ARMED->CAPTURE cycle.
  assign w_hit      = (r_state == S_ARMED) && cfg_trig_en && bus.wb_have_inst &&
                      (bus.wb_pc == cfg_trig_pc);
  assign w_cand     = bus.wb_have_inst && ((r_state == S_CAPT) || w_hit) &&
                      (!cfg_filter || (bus.wb_ena && (bus.wb_reg != '0)));
  assign w_full     = (r_level == (AW+1)'(DEPTH));
  assign w_pop      = (r_level != '0) && bus.out_ready;
  assign w_lose     = w_cand && w_full && !w_pop;
  assign w_wr       = w_cand && (!w_lose || cfg_wrap);
  assign w_inc      = w_cand && !w_lose;
  assign w_adv_head = w_pop || (w_lose && cfg_wrap);
  assign w_post_nxt = r_post + 16'd1;
  assign w_done     = w_cand && (cfg_post != 16'd0) && (w_post_nxt == cfg_post);

  assign w_rec = '{pc: bus.wb_pc, value: bus.wb_value, rd: bus.wb_reg,
                   ena: bus.wb_ena, seq: r_seq};

  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_seq   <= '0;
      r_post  <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
      r_level <= '0;
      r_seq   <= '0;
      r_post  <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (bus.wb_have_inst) r_seq <= r_seq + SEQW'(1);
      if (w_wr)             r_tail <= r_tail + AW'(1);
      if (w_adv_head)       r_head <= r_head + AW'(1);
      if (w_inc && !w_pop)      r_level <= r_level + (AW+1)'(1);
      else if (w_pop && !w_inc) r_level <= r_level - (AW+1)'(1);
      if (w_lose) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
      end
      if (w_cand) r_post <= w_post_nxt;

      if (!cfg_en) r_state <= S_IDLE;
      else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_ARMED;
            r_post  <= '0;
          end
          S_ARMED: begin
            if (w_done)                        r_state <= S_DONE;
            else if (!cfg_trig_en || w_hit)    r_state <= S_CAPT;
          end
          S_CAPT:  if (w_done) r_state <= S_DONE;
          default: r_state <= S_DONE;
        endcase
      end
    end
  end

  // Storage needs no reset: nothing is visible until level is non-zero.
  always_ff @(posedge cpu_clk) begin
    if (w_wr) r_mem[r_tail] <= w_rec;
  end

  assign w_head_rec    = (r_level != '0) ? r_mem[r_head] : '0;
  assign bus.out_valid = (r_level != '0);
  assign bus.out_pc    = w_head_rec.pc;
  assign bus.out_value = w_head_rec.value;
  assign bus.out_reg   = w_head_rec.rd;
  assign bus.out_ena   = w_head_rec.ena;
  assign bus.out_seq   = w_head_rec.seq;

  assign level    = r_level;
  assign drop_cnt = r_drop;
  assign overflow = r_ovf;
  assign state    = r_state;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed plus randomized bench for wb_trace_buffer against a queue-based model.
module tb_wb_trace_buffer;
  localparam int XLEN = 32, REGW = 5, DEPTH = 16, SEQW = 16;
  localparam int AW = $clog2(DEPTH);

  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  always #5 cpu_clk = ~cpu_clk;

  wb_trace_buffer_if #(.XLEN(XLEN), .REGW(REGW), .SEQW(SEQW)) bus();

  logic            clr, cfg_en, cfg_filter, cfg_wrap, cfg_trig_en;
  logic [XLEN-1:0] cfg_trig_pc;
  logic [15:0]     cfg_post;
  logic [AW:0]     level;
  logic [15:0]     drop_cnt;
  logic            overflow;
  logic [1:0]      state;

  wb_trace_buffer #(.XLEN(XLEN), .REGW(REGW), .DEPTH(DEPTH), .SEQW(SEQW)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .bus(bus.slave), .clr(clr),
    .cfg_en(cfg_en), .cfg_filter(cfg_filter), .cfg_wrap(cfg_wrap),
    .cfg_trig_en(cfg_trig_en), .cfg_trig_pc(cfg_trig_pc), .cfg_post(cfg_post),
    .level(level), .drop_cnt(drop_cnt), .overflow(overflow), .state(state)
  );

  typedef struct {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] value;
    logic [REGW-1:0] rd;
    logic            ena;
    logic [SEQW-1:0] seq;
  } rec_t;

  rec_t  q[$];
  int    m_seq, m_drop, m_ovf, m_st, m_pcnt;
  int    tests = 0, fails = 0;
  string phase = "reset";

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s: got %0h want %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_seq = 0; m_drop = 0; m_ovf = 0; m_st = 0; m_pcnt = 0;
  endtask

  // State numbering: 0 idle, 1 armed, 2 capture, 3 done.
  task automatic model_step();
    rec_t r;
    bit   hit, keep, pop;
    if (!cpu_rst || clr) begin
      model_reset();
      return;
    end
    hit  = (m_st == 1) && cfg_trig_en && bus.wb_have_inst && (bus.wb_pc == cfg_trig_pc);
    keep = bus.wb_have_inst && ((m_st == 2) || hit) &&
           (!cfg_filter || (bus.wb_ena && bus.wb_reg != 0));
    pop  = bus.out_ready && (q.size() > 0);
    r.pc = bus.wb_pc; r.value = bus.wb_value; r.rd = bus.wb_reg;
    r.ena = bus.wb_ena; r.seq = SEQW'(m_seq);
    if (pop) void'(q.pop_front());
    if (keep) begin
      if (q.size() < DEPTH) q.push_back(r);
      else begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
        if (cfg_wrap) begin
          void'(q.pop_front());
          q.push_back(r);
        end
      end
      m_pcnt++;
    end
    if (bus.wb_have_inst) m_seq = (m_seq + 1) % (1 << SEQW);
    if (!cfg_en) m_st = 0;
    else if (m_st == 0) begin
      m_st = 1; m_pcnt = 0;
    end else if (m_st != 3) begin
      if (m_st == 1 && (!cfg_trig_en || hit)) m_st = 2;
      if (keep && cfg_post != 0 && m_pcnt == cfg_post) m_st = 3;
    end
  endtask

  task automatic check_all();
    rec_t h;
    h = '{pc: '0, value: '0, rd: '0, ena: 1'b0, seq: '0};
    if (q.size() > 0) h = q[0];
    chk("valid", bus.out_valid, q.size() != 0);
    chk("level", level, q.size());
    chk("drop", drop_cnt, m_drop);
    chk("ovf", overflow, m_ovf);
    chk("state", state, m_st);
    chk("pc", bus.out_pc, h.pc);
    chk("value", bus.out_value, h.value);
    chk("reg", bus.out_reg, h.rd);
    chk("ena", bus.out_ena, h.ena);
    chk("seq", bus.out_seq, h.seq);
  endtask

  task automatic tick();
    model_step();
    @(posedge cpu_clk);
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    bus.wb_have_inst = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic retire(logic [XLEN-1:0] pc, logic ena, logic [REGW-1:0] rd);
    bus.wb_have_inst = 1'b1;
    bus.wb_pc = pc; bus.wb_ena = ena; bus.wb_reg = rd; bus.wb_value = $urandom;
    tick();
    bus.wb_have_inst = 1'b0;
  endtask

  task automatic restart();
    clr = 1'b1; tick(); clr = 1'b0;
    idle(2);
  endtask

  initial begin
    bus.wb_have_inst = 1'b0; bus.wb_pc = '0; bus.wb_ena = 1'b0;
    bus.wb_reg = '0; bus.wb_value = '0; bus.out_ready = 1'b0;
    clr = 1'b0; cfg_en = 1'b0; cfg_filter = 1'b0; cfg_wrap = 1'b0;
    cfg_trig_en = 1'b0; cfg_trig_pc = '0; cfg_post = '0;
    model_reset();

    #1 cpu_rst = 1'b0;
    #1 check_all();
    @(negedge cpu_clk) cpu_rst = 1'b1;

    phase = "t1";
    cfg_en = 1'b1;
    idle(2);
    chk("capt", state, 2);
    retire(32'h0, 1'b1, 5'd1);
    chk("valid_next", bus.out_valid, 1'b1);
    retire(32'h4, 1'b1, 5'd2);
    retire(32'h8, 1'b1, 5'd3);
    chk("lvl3", level, 3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("dseq", bus.out_seq, i);
      chk("dpc", bus.out_pc, i * 4);
      tick();
    end
    chk("empty", level, 0);

    phase = "t2";
    bus.out_ready = 1'b0; cfg_filter = 1'b1;
    restart();
    retire(32'h10, 1'b1, 5'd0);
    retire(32'h14, 1'b1, 5'd5);
    retire(32'h18, 1'b0, 5'd9);
    retire(32'h1C, 1'b1, 5'd7);
    chk("lvl2", level, 2);
    chk("seq1", bus.out_seq, 1);
    chk("reg5", bus.out_reg, 5);
    bus.out_ready = 1'b1; idle(1);
    chk("seq3", bus.out_seq, 3);
    chk("reg7", bus.out_reg, 7);
    idle(1);
    cfg_filter = 1'b0;

    phase = "t3";
    bus.out_ready = 1'b0;
    restart();
    for (int i = 0; i < 20; i++) retire(32'h200 + i * 4, 1'b1, 5'd1);
    chk("full", level, 16);
    chk("drop4", drop_cnt, 4);
    chk("ovf", overflow, 1);
    chk("head0", bus.out_seq, 0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("dseq", bus.out_seq, i);
      tick();
    end
    bus.out_ready = 1'b0; cfg_wrap = 1'b1;
    restart();
    for (int i = 0; i < 20; i++) retire(32'h200 + i * 4, 1'b1, 5'd1);
    chk("wfull", level, 16);
    chk("wdrop4", drop_cnt, 4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("wseq", bus.out_seq, 4 + i);
      tick();
    end
    cfg_wrap = 1'b0;

    phase = "t4";
    bus.out_ready = 1'b0;
    cfg_trig_en = 1'b1; cfg_trig_pc = 32'h100; cfg_post = 16'd3;
    restart();
    chk("armed", state, 1);
    for (int i = 0; i < 8; i++) retire(32'hF8 + i * 4, 1'b1, 5'd2);
    chk("lvl3", level, 3);
    chk("done", state, 3);
    chk("trigpc", bus.out_pc, 32'h100);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("dpc", bus.out_pc, 32'h100 + i * 4);
      tick();
    end
    cfg_trig_en = 1'b0; cfg_post = 16'd0;

    phase = "t5";
    bus.out_ready = 1'b0;
    restart();
    for (int i = 0; i < 16; i++) retire(32'h400 + i * 4, 1'b1, 5'd4);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.wb_have_inst = 1'b1; bus.wb_pc = 32'h500 + i * 4;
      bus.wb_ena = 1'b1; bus.wb_reg = 5'd6; bus.wb_value = $urandom;
      tick();
      chk("stay16", level, 16);
    end
    bus.wb_have_inst = 1'b0;
    chk("nodrop", drop_cnt, 0);
    idle(16);

    phase = "rand";
    restart();
    for (int seg = 0; seg < 8; seg++) begin
      cfg_filter  = ($urandom_range(0, 2) == 0);
      cfg_wrap    = $urandom_range(0, 1);
      cfg_trig_en = ($urandom_range(0, 2) == 0);
      cfg_trig_pc = 32'h20;
      cfg_post    = 16'($urandom_range(0, 5));
      for (int i = 0; i < 50; i++) begin
        bus.wb_have_inst = ($urandom_range(0, 3) != 0);
        bus.wb_pc    = 32'($urandom_range(0, 15)) << 2;
        bus.wb_ena   = $urandom_range(0, 1);
        bus.wb_reg   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        bus.wb_value = $urandom;
        bus.out_ready = ($urandom_range(0, 2) == 0);
        clr    = ($urandom_range(0, 99) == 0);
        cfg_en = ($urandom_range(0, 59) != 0);
        tick();
      end
    end
    clr = 1'b0; cfg_en = 1'b1; cfg_filter = 1'b0; cfg_trig_en = 1'b0;
    cfg_post = 16'd0; bus.wb_have_inst = 1'b0;

    phase = "t6";
    bus.out_ready = 1'b0;
    restart();
    for (int i = 0; i < 5; i++) retire(32'h600 + i * 4, 1'b1, 5'd8);
    chk("lvl5", level, 5);
    #2 cpu_rst = 1'b0;
    #1;
    model_reset();
    chk("rlvl", level, 0);
    chk("rvalid", bus.out_valid, 0);
    chk("ridle", state, 0);
    check_all();
    @(negedge cpu_clk) cpu_rst = 1'b1;
    idle(2);
    retire(32'h700, 1'b1, 5'd9);
    chk("seq0", bus.out_seq, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
